// File: rtl/router_pkt_tx_if.sv
// Host-side and router-side signals of the packet source, bundled for port connection.
// The slave modport is the packet source itself; the master modport is whoever drives it.
interface router_pkt_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [1:0] dest_addr;
    logic       corrupt_parity;
    logic       start;
    logic       busy;
    logic       err;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_busy;
    logic       done;
    logic       pkt_err;

    modport master (
        output wr_en, wr_data, dest_addr, corrupt_parity, start, busy, err,
        input  wr_ready, pkt_valid, data_out, tx_busy, done, pkt_err
    );

    modport slave (
        input  wr_en, wr_data, dest_addr, corrupt_parity, start, busy, err,
        output wr_ready, pkt_valid, data_out, tx_busy, done, pkt_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers up to 63 payload bytes, then sends header, payload
// and XOR parity under busy flow control, and records the router's err verdict.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 3
) (
    input  logic           clk,
    input  logic           reset,
    router_pkt_tx_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    state_t      r_state;
    logic [7:0]  r_buf [0:63];
    logic [5:0]  r_count;
    logic [5:0]  r_len;
    logic [5:0]  r_idx;
    logic        r_corrupt;
    logic [7:0]  r_par;
    logic [7:0]  r_data_out;
    logic        r_pkt_valid;
    logic        r_tx_busy;
    logic        r_done;
    logic        r_pkt_err;
    logic [15:0] r_gap_cnt;

    logic        w_idle;
    logic        w_wr_ready;
    logic        w_wr_accept;
    logic        w_consume;
    logic [7:0]  w_par_next;
    logic [5:0]  w_next_idx;
    logic [5:0]  w_rd_addr;
    logic [7:0]  w_rd_data;

    assign w_idle      = (r_state == S_IDLE);
    assign w_wr_ready  = w_idle && (r_count != 6'd63) && !bus.start;
    assign w_wr_accept = w_wr_ready && bus.wr_en;
    assign w_consume   = ((r_state == S_HEADER) || (r_state == S_PAYLOAD) ||
                          (r_state == S_PARITY)) && !bus.busy;
    // The byte on data_out is the one being consumed, so it folds straight into parity.
    assign w_par_next  = r_par ^ r_data_out;
    assign w_next_idx  = r_idx + 6'd1;
    assign w_rd_addr   = (r_state == S_HEADER) ? 6'd0 : w_next_idx;
    assign w_rd_data   = r_buf[w_rd_addr];

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_buf[r_count] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= 6'd0;
            r_len       <= 6'd0;
            r_idx       <= 6'd0;
            r_corrupt   <= 1'b0;
            r_par       <= 8'd0;
            r_data_out  <= 8'd0;
            r_pkt_valid <= 1'b0;
            r_tx_busy   <= 1'b0;
            r_done      <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_gap_cnt   <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_accept) begin
                        r_count <= r_count + 6'd1;
                    end
                    if (bus.start && (r_count != 6'd0)) begin
                        r_state     <= S_HEADER;
                        r_len       <= r_count;
                        r_corrupt   <= bus.corrupt_parity;
                        r_pkt_err   <= 1'b0;
                        r_par       <= 8'd0;
                        r_idx       <= 6'd0;
                        r_data_out  <= {r_count, bus.dest_addr};
                        r_pkt_valid <= 1'b1;
                        r_tx_busy   <= 1'b1;
                    end
                end
                S_HEADER: begin
                    if (w_consume) begin
                        r_par      <= w_par_next;
                        r_data_out <= w_rd_data;
                        r_state    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_consume) begin
                        r_par <= w_par_next;
                        if (r_idx == r_len - 6'd1) begin
                            r_state     <= S_PARITY;
                            r_pkt_valid <= 1'b0;
                            r_data_out  <= w_par_next ^ {7'd0, r_corrupt};
                        end else begin
                            r_idx      <= w_next_idx;
                            r_data_out <= w_rd_data;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_consume) begin
                        r_state    <= S_GAP;
                        r_data_out <= 8'd0;
                        r_gap_cnt  <= 16'd0;
                    end
                end
                S_GAP: begin
                    if (bus.err) begin
                        r_pkt_err <= 1'b1;
                    end
                    if (r_gap_cnt == 16'(GAP_CYCLES - 1)) begin
                        r_state   <= S_IDLE;
                        r_count   <= 6'd0;
                        r_done    <= 1'b1;
                        r_tx_busy <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.pkt_valid = r_pkt_valid;
    assign bus.data_out  = r_data_out;
    assign bus.tx_busy   = r_tx_busy;
    assign bus.done      = r_done;
    assign bus.pkt_err   = r_pkt_err;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed and randomized bench for router_pkt_tx: a queue models the host buffer and
// the expected byte stream is rebuilt per packet from the header/payload/parity rules.
module tb_router_pkt_tx;
    localparam int GAP = 3;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [7:0] m_buf[$];

    router_pkt_tx_if intf ();

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic exp_rdy;
        intf.wr_en   = 1'b1;
        intf.wr_data = d;
        intf.start   = 1'b0;
        #1;
        exp_rdy = (m_buf.size() < 63);
        check("wr_ready", intf.wr_ready, exp_rdy);
        if (exp_rdy) m_buf.push_back(d);
        @(posedge clk); #1;
        intf.wr_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, intf.pkt_valid, 1'b0);
        check({tag, "_data"}, intf.data_out, 8'h00);
        check({tag, "_txbusy"}, intf.tx_busy, 1'b0);
        check({tag, "_done"}, intf.done, 1'b0);
    endtask

    // Sends the buffered packet, checking every port cycle against the expected stream.
    task automatic send_packet(input logic [1:0] dest, input logic corrupt, input bit rnd_busy,
                               input int hold_k, input int hold_n, input bit err_gap,
                               input bit rst_mid, output logic [7:0] hdr_obs,
                               output logic [7:0] par_obs);
        logic [7:0] exp_s[$];
        logic [7:0] p;
        int len;
        int k;
        int held;
        int cyc;
        bit b;
        len = m_buf.size();
        p = {len[5:0], dest};
        exp_s.push_back(p);
        foreach (m_buf[i]) begin
            exp_s.push_back(m_buf[i]);
            p = p ^ m_buf[i];
        end
        exp_s.push_back(p ^ {7'd0, corrupt});
        hdr_obs = 8'h00;
        par_obs = 8'h00;

        intf.dest_addr      = dest;
        intf.corrupt_parity = corrupt;
        intf.start          = 1'b1;
        intf.wr_en          = 1'b0;
        intf.busy           = 1'b0;
        @(posedge clk); #1;
        intf.start          = 1'b0;
        intf.dest_addr      = 2'($urandom);
        intf.corrupt_parity = 1'($urandom);

        k = 0; held = 0; cyc = 0;
        while (k < len + 2 && cyc < 2000) begin
            check("tx_data", intf.data_out, exp_s[k]);
            check("tx_valid", intf.pkt_valid, (k <= len));
            check("tx_busy", intf.tx_busy, 1'b1);
            check("tx_wr_ready", intf.wr_ready, 1'b0);
            check("tx_pkt_err", intf.pkt_err, 1'b0);
            check("tx_done", intf.done, 1'b0);
            if (k == 0) hdr_obs = intf.data_out;
            if (k == len + 1) par_obs = intf.data_out;
            if (rst_mid && k == 1) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_idle_outputs("rst_mid");
                check("rst_mid_wr_ready", intf.wr_ready, 1'b1);
                m_buf.delete();
                return;
            end
            if (k == hold_k && held < hold_n) begin
                b = 1'b1;
                held++;
            end else if (rnd_busy) begin
                b = ($urandom_range(0, 3) == 0);
            end else begin
                b = 1'b0;
            end
            intf.busy    = b;
            intf.wr_en   = 1'($urandom);
            intf.wr_data = 8'($urandom);
            @(posedge clk); #1;
            if (!b) k++;
            cyc++;
        end
        if (cyc >= 2000) check("tx_timeout", 32'(cyc), 32'(len + 2));

        intf.wr_en = 1'b0;
        intf.err   = err_gap;
        for (int j = 0; j < GAP; j++) begin
            check("gap_data", intf.data_out, 8'h00);
            check("gap_valid", intf.pkt_valid, 1'b0);
            check("gap_done", intf.done, 1'b0);
            check("gap_txbusy", intf.tx_busy, 1'b1);
            intf.busy = 1'($urandom);
            @(posedge clk); #1;
        end
        intf.err  = 1'b0;
        intf.busy = 1'b0;
        check("done_pulse", intf.done, 1'b1);
        check("done_txbusy", intf.tx_busy, 1'b0);
        check("done_pkt_err", intf.pkt_err, err_gap);
        check("done_data", intf.data_out, 8'h00);
        @(posedge clk); #1;
        check("done_low", intf.done, 1'b0);
        check("after_pkt_err", intf.pkt_err, err_gap);
        m_buf.delete();
    endtask

    initial begin
        logic [7:0] h;
        logic [7:0] q;
        int nw;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        intf.wr_en = 1'b0; intf.wr_data = 8'h00; intf.dest_addr = 2'd0;
        intf.corrupt_parity = 1'b0; intf.start = 1'b0; intf.busy = 1'b0; intf.err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle_outputs("reset");
        check("reset_pkt_err", intf.pkt_err, 1'b0);
        check("reset_wr_ready", intf.wr_ready, 1'b1);

        // Basic 3-byte packet to port 2.
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        send_packet(2'd2, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, h, q);
        check("basic_hdr", h, 8'h0E);
        check("basic_par", q, 8'h0E);

        // Same packet with busy holding 0x22 for two extra cycles.
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        send_packet(2'd2, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0, h, q);
        check("hold_par", q, 8'h0E);

        // Corrupted parity with err reported during the gap.
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        send_packet(2'd2, 1'b1, 1'b0, -1, 0, 1'b1, 1'b0, h, q);
        check("corrupt_par", q, 8'h0F);

        // Full buffer: the 64th write is dropped; next start clears pkt_err.
        for (int i = 0; i < 64; i++) write_byte(8'($urandom));
        send_packet(2'd0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, h, q);
        check("full_hdr", h, 8'hFC);

        // Start with an empty buffer does nothing.
        intf.start = 1'b1;
        @(posedge clk); #1;
        intf.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle_outputs("empty_start");
            @(posedge clk); #1;
        end

        // Reset in the middle of the payload, then a 1-byte packet.
        write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
        send_packet(2'd1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1, h, q);
        write_byte(8'hA5);
        send_packet(2'd1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, h, q);
        check("one_hdr", h, 8'h05);
        check("one_par", q, 8'hA0);

        // Randomized packets with random busy, parity corruption and err.
        for (int n = 0; n < 20; n++) begin
            nw = $urandom_range(1, 66);
            for (int i = 0; i < nw; i++) write_byte(8'($urandom));
            send_packet(2'($urandom), 1'($urandom), 1'b1, -1, 0, 1'($urandom), 1'b0, h, q);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the 3x1 router: buffers payload bytes from a host, then serialises one router packet onto the router input port (header, payload, parity) under the router's `busy` flow control. It is the transmitting end of the router's receive/parity-check path. It computes the parity byte the router checks and captures the router's `err` verdict for each packet. It is used as the traffic generator in system benches and as the upstream interface block in integration.

## Interface
- `GAP_CYCLES`, default 3: idle cycles after the parity byte before returning to IDLE (minimum 1).
- `clk` in 1: clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-low.
- `wr_en` in 1: host payload write strobe.
- `wr_data` in 8: payload byte.
- `wr_ready` out 1: write accepted this cycle; equals `idle & count<63 & ~start`.
- `dest_addr` in 2: destination port (0..2), sampled at start.
- `corrupt_parity` in 1: sampled at start; inverts bit 0 of the transmitted parity.
- `start` in 1: request transmission of the buffered payload.
- `busy` in 1: router busy; the current byte is held while high.
- `err` in 1: router parity-error flag.
- `pkt_valid` out 1: router packet-valid.
- `data_out` out 8: router data input.
- `tx_busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on GAP→IDLE.
- `pkt_err` out 1: sticky; `err` seen during GAP; cleared on the next accepted start.

## Operation
- 64×8 payload buffer with 6-bit `count`.
- In IDLE, an accepted write stores `buf[count]` and does `count+1`.
- Writes are dropped when not IDLE, when `count==63`, or when `start` is high.
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: `start & count!=0` → HEADER.
  - Latch `dest_addr`, `corrupt_parity` and `len=count`.
  - Clear `pkt_err`, parity register and read index.
  - `start` with `count==0` is ignored.
  - `dest_addr==3` is transmitted unchanged; the router drops it.
- HEADER: `data_out={len[5:0],dest_addr}`, `pkt_valid=1`. Go to PAYLOAD when consumed.
- PAYLOAD: `data_out=buf[idx]`, `pkt_valid=1`. On consumption, `idx+1`. After byte `len-1` is consumed → PARITY.
- PARITY: `data_out=par ^ {7'b0,corrupt}`, `pkt_valid=0`. Go to GAP when consumed.
- Consumption rule: a byte is consumed at a rising edge where the state is HEADER, PAYLOAD or PARITY and `busy==0`.
- While `busy==1`, `data_out`, `pkt_valid` and state hold unchanged.
- Parity register: `par ^= byte` on each consumed header and payload byte. Its value at PARITY is the XOR of the header and all payload bytes.
- GAP: `pkt_valid=0`, `data_out=0` for `GAP_CYCLES` cycles; `busy` is ignored. `err==1` in any GAP cycle sets `pkt_err`.
- GAP exit → IDLE, `count=0`, `done=1` for one cycle.
- Outputs are registered and change only on clock edges.

## Timing
- Reset values: state IDLE, `count=0`, `pkt_valid=0`, `data_out=0`, `done=0`, `pkt_err=0`, `tx_busy=0`. `wr_ready=1` when `start=0`.
- Start latency: header appears on `data_out`, with `pkt_valid=1`, the cycle after `start` is sampled.
- With `busy` low throughout, a packet occupies 1 + len + 1 cycles on the port. `pkt_valid` is high for exactly 1+len cycles, followed by the parity byte with `pkt_valid=0`.
- `done` rises `GAP_CYCLES` cycles after the parity-consumption edge.
- Minimum spacing between headers of back-to-back packets: len+2+`GAP_CYCLES`+1 cycles, plus host reload time.
- Reset asserted mid-packet: next cycle all outputs return to reset values; buffered bytes are discarded (`count=0`).
- `start` while `tx_busy`: ignored, not queued.

## Test plan
- Write 0x11,0x22,0x33; start with `dest_addr=2`, `busy=0` → `data_out` 0x0E,0x11,0x22,0x33 with `pkt_valid=1`; then 0x0E with `pkt_valid=0`; `done` pulses 3 cycles after the parity edge.
- Same packet with `busy` high for 2 cycles while 0x22 is presented → 0x22 held 3 cycles, `pkt_valid` stays 1, sequence otherwise unchanged.
- Same packet with `corrupt_parity=1`; drive `err=1` during GAP → parity byte 0x0F, `pkt_err=1` after GAP. The next start clears `pkt_err`.
- Write 64 bytes → 64th write has `wr_ready=0` and is dropped. Start with `dest_addr=0` → header 0xFC, 63 payload bytes, correct XOR parity.
- `start` with `count=0` → no activity, `tx_busy` stays 0. Writes attempted during transmission → dropped, `count` unaffected.
- Reset low during PAYLOAD → `pkt_valid=0`, `data_out=0`, IDLE. A subsequent 1-byte packet (0xA5, addr 1) sends header 0x05, 0xA5, parity 0xA0.
